// File: rtl/noc_packet_consumer.sv
// NoC ejection-port packet consumer.
// Turns 64-bit flits back into a byte-wide AXI stream.
module noc_packet_consumer #(
  parameter int NocDataWidth             = 64,
  parameter int AxisDataWidth            = 8,
  parameter int flitTypeSize             = 2,
  parameter int NocVirtualChannelIdWidth = 3,
  parameter int NocBroadcastWidth        = 1,
  parameter int TIdWidth                 = 8,
  parameter int TDestWidth               = 11
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc,
  input  logic [NocDataWidth-1:0]             network_flit_i,
  input  logic [flitTypeSize-1:0]             network_flit_type_i,
  input  logic [NocVirtualChannelIdWidth-1:0] network_vc_i,
  input  logic [NocBroadcastWidth-1:0]        network_broadcast_i,
  input  logic                                network_valid_i,
  output logic                                network_ready_o,
  output logic [AxisDataWidth-1:0]            m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [TIdWidth-1:0]                 m_axis_tid,
  output logic [TDestWidth-1:0]               m_axis_tdest,
  output logic [TDestWidth-1:0]               m_axis_tuser,
  output logic                                protocol_error_o
);

  typedef enum logic {IDLE, IN_PACKET} state_t;

  // Slot 0 carries the held byte, slots 1..8 the flit bytes.
  localparam int Slots = 9;

  state_t              state_q, state_d;
  logic [Slots*8-1:0]  buf_q, buf_d;
  logic [Slots-1:0]    mask_q, mask_d;
  logic [Slots-1:0]    new_mask;
  logic                term_q, term_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_v_q, hold_v_d;
  logic [TIdWidth-1:0] tid_q, tid_d;
  logic [10:0]         dst_q, dst_d;
  logic [10:0]         src_q, src_d;

  logic [Slots-1:0]    first_oh;
  logic [7:0]          byte_sel;
  logic                loaded;
  logic                hs;
  logic                last_em;
  logic                final_em;
  logic                accept;
  logic                err;
  logic                is_head;
  logic                is_ht;
  logic                is_body;
  logic                is_tail;
  logic                unused_sideband;

  assign unused_sideband = ^{network_vc_i, network_broadcast_i};

  assign is_ht   = network_flit_type_i == 2'b11;
  assign is_head = (network_flit_type_i == 2'b00) | is_ht;
  assign is_body = network_flit_type_i == 2'b01;
  assign is_tail = network_flit_type_i == 2'b10;

  // Pick the lowest pending slot as the byte on the bus.
  always_comb begin
    first_oh = mask_q & (~mask_q + 9'd1);
    byte_sel = '0;
    for (int i = 0; i < Slots; i++) begin
      byte_sel = byte_sel
               | (buf_q[i*8 +: 8] & {8{first_oh[i]}});
    end
  end

  assign loaded   = |mask_q;
  assign last_em  = (mask_q & ~first_oh) == '0;
  assign hs       = loaded & m_axis_tready & ~rst_noc;
  assign final_em = hs & last_em;

  assign network_ready_o  = ~rst_noc & (~loaded | final_em);
  assign accept           = network_valid_i & network_ready_o;
  assign protocol_error_o = err;

  assign m_axis_tvalid = loaded & ~rst_noc;
  assign m_axis_tdata  = rst_noc ? '0 : byte_sel;
  assign m_axis_tlast  = m_axis_tvalid & term_q & last_em;
  assign m_axis_tid    = rst_noc ? '0 : tid_q;
  assign m_axis_tdest  = rst_noc ? '0 : dst_q;
  assign m_axis_tuser  = rst_noc ? '0 : src_q;

  // Next state: retire emitted slots, decode accepted flits.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    mask_d   = mask_q;
    term_d   = term_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    tid_d    = tid_q;
    dst_d    = dst_q;
    src_d    = src_q;
    new_mask = '0;
    err      = 1'b0;
    if (hs) mask_d = mask_q & ~first_oh;
    if (accept) begin
      unique case (1'b1)
        is_head: begin
          new_mask = {4'b0, ~network_flit_i[35:32], 1'b0};
          err      = (state_q == IN_PACKET)
                   | (is_ht & ~|new_mask);
          buf_d    = {network_flit_i, 8'h00};
          mask_d   = new_mask;
          term_d   = is_ht;
          hold_d   = '0;
          hold_v_d = 1'b0;
          tid_d    = TIdWidth'(network_flit_i[41:37]);
          dst_d    = network_flit_i[63:53];
          src_d    = network_flit_i[52:42];
          state_d  = is_ht ? IDLE : IN_PACKET;
        end
        is_body: begin
          if (state_q == IDLE) begin
            err = 1'b1;
          end else begin
            new_mask = {1'b0, 7'h7F, hold_v_q};
            buf_d    = {network_flit_i, hold_q};
            mask_d   = new_mask;
            term_d   = 1'b0;
            hold_d   = network_flit_i[63:56];
            hold_v_d = 1'b1;
          end
        end
        is_tail: begin
          if (state_q == IDLE) begin
            err = 1'b1;
          end else begin
            new_mask = {1'b0, ~network_flit_i[62:56],
                        hold_v_q};
            err      = ~|new_mask;
            buf_d    = {network_flit_i, hold_q};
            mask_d   = new_mask;
            term_d   = 1'b1;
            hold_d   = '0;
            hold_v_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, flit buffer, hold byte and header registers.
  always_ff @(posedge clk_noc) begin
    if (rst_noc) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      mask_q   <= '0;
      term_q   <= 1'b0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      tid_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      term_q   <= term_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      tid_q    <= tid_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
    end
  end

endmodule

// File: tb/tb_noc_packet_consumer.sv
// Scoreboard bench for noc_packet_consumer.
// Expected beats are queued as flits are driven.
module tb_noc_packet_consumer;

  logic        clk_noc = 1'b0;
  logic        rst_noc = 1'b1;
  logic [63:0] network_flit_i = '0;
  logic [1:0]  network_flit_type_i = '0;
  logic [2:0]  network_vc_i = '0;
  logic [0:0]  network_broadcast_i = '0;
  logic        network_valid_i = 1'b0;
  logic        network_ready_o;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [10:0] m_axis_tdest;
  logic [10:0] m_axis_tuser;
  logic        protocol_error_o;

  noc_packet_consumer dut (
    .clk_noc             (clk_noc),
    .rst_noc             (rst_noc),
    .network_flit_i      (network_flit_i),
    .network_flit_type_i (network_flit_type_i),
    .network_vc_i        (network_vc_i),
    .network_broadcast_i (network_broadcast_i),
    .network_valid_i     (network_valid_i),
    .network_ready_o     (network_ready_o),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tid          (m_axis_tid),
    .m_axis_tdest        (m_axis_tdest),
    .m_axis_tuser        (m_axis_tuser),
    .protocol_error_o    (protocol_error_o)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [7:0]  tid;
    logic [10:0] dst;
    logic [10:0] src;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [10:0] m_dst = '0;
  logic [10:0] m_src = '0;
  logic [4:0]  m_tid = '0;
  logic        stall_en = 1'b0;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  function automatic logic [63:0] hdr(
    input logic [10:0] d, input logic [10:0] s,
    input logic [4:0] t, input logic [3:0] p,
    input logic [31:0] x);
    return {d, s, t, 1'b1, p, x};
  endfunction

  function automatic logic [63:0] tl(
    input logic [6:0] p, input logic [55:0] x);
    return {1'b1, p, x};
  endfunction

  task automatic push(input logic [7:0] d, input logic l);
    exp_q.push_back({d, l, {3'b000, m_tid}, m_dst, m_src});
  endtask

  // Drive one flit; returns the error flag seen in its accept cycle.
  task automatic send_flit(input logic [1:0] t,
                           input logic [63:0] f,
                           output logic err,
                           output logic ok);
    network_flit_type_i = t;
    network_flit_i      = f;
    network_valid_i     = 1'b1;
    ok  = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_noc);
      if (network_ready_o) begin
        ok  = 1'b1;
        err = protocol_error_o;
        break;
      end
    end
    @(posedge clk_noc);
    #1;
    network_valid_i = 1'b0;
  endtask

  task automatic drain(output int left);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_noc);
      if (exp_q.size() == 0 && !m_axis_tvalid) break;
    end
    left = exp_q.size() + int'(m_axis_tvalid);
    @(posedge clk_noc);
    #1;
  endtask

  // Scoreboard and stall-stability monitor.
  initial begin : monitor
    beat_t       e;
    logic [39:0] obs;
    logic [39:0] snap;
    logic        stalled;
    stalled = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk_noc);
      obs = {m_axis_tvalid, m_axis_tdata, m_axis_tlast,
             m_axis_tid, m_axis_tdest, m_axis_tuser};
      if (rst_noc) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (obs !== snap) begin
            errors++;
            $display("FAIL axis_stable got %h exp %h", obs, snap);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got d=%h l=%b",
                     m_axis_tdata, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if ({m_axis_tdata, m_axis_tlast, m_axis_tid,
                 m_axis_tdest, m_axis_tuser} !== e) begin
              errors++;
              $display("FAIL beat got %h/%b/%h/%h/%h exp %h/%b/%h/%h/%h",
                       m_axis_tdata, m_axis_tlast, m_axis_tid,
                       m_axis_tdest, m_axis_tuser,
                       e.d, e.l, e.tid, e.dst, e.src);
            end
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        snap    = obs;
      end
    end
  end

  task automatic test_reset;
    rst_noc = 1'b1;
    repeat (2) @(posedge clk_noc);
    @(negedge clk_noc);
    checks++;
    if ({m_axis_tvalid, network_ready_o, m_axis_tlast,
         m_axis_tdata, m_axis_tid, m_axis_tdest,
         m_axis_tuser, protocol_error_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%b d=%h",
               m_axis_tvalid, network_ready_o, m_axis_tdata);
    end
    @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    @(negedge clk_noc);
    checks++;
    if (network_ready_o !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got r=%b v=%b exp r=1 v=0",
               network_ready_o, m_axis_tvalid);
    end
    @(posedge clk_noc);
    #1;
  endtask

  task automatic test_header_and_tail;
    logic err, ok;
    int   left;
    m_dst = 11'h005; m_src = 11'h003; m_tid = 5'd2;
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    push(8'hCC, 1'b1);
    send_flit(T_HT, hdr(m_dst, m_src, m_tid, 4'b1000,
                        32'h00CCBBAA), err, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL ht_accept got ok=%b err=%b exp ok=1 err=0",
               ok, err);
    end
    @(negedge clk_noc);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hAA) begin
      errors++;
      $display("FAIL ht_latency got v=%b d=%h exp v=1 d=aa",
               m_axis_tvalid, m_axis_tdata);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL ht_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_head_tail;
    logic e1, e2, o1, o2;
    int   left;
    m_dst = 11'h123; m_src = 11'h456; m_tid = 5'h1F;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h44, 0); push(8'h55, 0); push(8'h66, 1);
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e1, o1);
    send_flit(T_TAIL, tl(7'b1111100, 56'h6655), e2, o2);
    checks++;
    if (!o1 || !o2 || e1 !== 1'b0 || e2 !== 1'b0) begin
      errors++;
      $display("FAIL hdr_tail_accept got ok=%b%b err=%b%b exp 11/00",
               o1, o2, e1, e2);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL hdr_tail_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_body_hold;
    logic e1, e2, e3, o1, o2, o3;
    int   left;
    int   seen;
    m_dst = 11'h2AA; m_src = 11'h155; m_tid = 5'h0C;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h44, 0);
    for (int i = 1; i <= 7; i++) push(8'(i * 8'h11), 0);
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e1, o1);
    send_flit(T_BODY, 64'h8877665544332211, e2, o2);
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL body_drain got %0d left exp 0", left);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk_noc);
      if (m_axis_tvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL body_withhold got %0d valid cycles exp 0",
               seen);
    end
    @(posedge clk_noc);
    #1;
    push(8'h88, 1);
    send_flit(T_TAIL, tl(7'h7F, 56'h0), e3, o3);
    checks++;
    if (!(o1 && o2 && o3) || {e1, e2, e3} !== 3'b000) begin
      errors++;
      $display("FAIL body_accept got ok=%b%b%b err=%b%b%b exp 111/000",
               o1, o2, o3, e1, e2, e3);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL empty_tail_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_stall;
    logic e1, e2, o1, o2;
    int   left;
    m_dst = 11'h321; m_src = 11'h0F0; m_tid = 5'h05;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h44, 0); push(8'h55, 0); push(8'h66, 1);
    m_axis_tready = 1'b1;
    stall_en = 1'b1;
    fork
      while (stall_en) begin
        @(posedge clk_noc);
        #1;
        m_axis_tready = ~m_axis_tready;
      end
    join_none
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e1, o1);
    @(negedge clk_noc);
    checks++;
    if (network_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got %b exp 0", network_ready_o);
    end
    @(posedge clk_noc);
    #1;
    send_flit(T_TAIL, tl(7'b1111100, 56'h6655), e2, o2);
    checks++;
    if (!o1 || !o2 || e1 !== 1'b0 || e2 !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept got ok=%b%b err=%b%b exp 11/00",
               o1, o2, e1, e2);
    end
    drain(left);
    stall_en = 1'b0;
    @(posedge clk_noc);
    #2;
    m_axis_tready = 1'b1;
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL stall_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_errors;
    logic e, o, e2, o2, e3, o3;
    int   left;
    send_flit(T_BODY, 64'h0102030405060708, e, o);
    checks++;
    if (!o || e !== 1'b1) begin
      errors++;
      $display("FAIL body_idle_err got ok=%b err=%b exp 1/1", o, e);
    end
    @(negedge clk_noc);
    checks++;
    if (protocol_error_o !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got err=%b v=%b exp 0/0",
               protocol_error_o, m_axis_tvalid);
    end
    @(posedge clk_noc);
    #1;
    send_flit(T_HT, hdr(11'h1, 11'h2, 5'h3, 4'hF, 32'h0), e, o);
    checks++;
    if (!o || e !== 1'b1) begin
      errors++;
      $display("FAIL empty_ht_err got ok=%b err=%b exp 1/1", o, e);
    end
    m_dst = 11'h00A; m_src = 11'h00B; m_tid = 5'h01;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h44, 0);
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e, o);
    send_flit(T_TAIL, tl(7'h7F, 56'h0), e2, o2);
    checks++;
    if (!o || !o2 || e !== 1'b0 || e2 !== 1'b1) begin
      errors++;
      $display("FAIL empty_tail_err got ok=%b%b err=%b%b exp 11/01",
               o, o2, e, e2);
    end
    drain(left);
    m_dst = 11'h0C0; m_src = 11'h0D0; m_tid = 5'h11;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h44, 0);
    for (int i = 1; i <= 7; i++) push(8'(i * 8'h11), 0);
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e, o);
    send_flit(T_BODY, 64'h8877665544332211, e2, o2);
    drain(left);
    m_dst = 11'h7FF; m_src = 11'h001; m_tid = 5'h0A;
    push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0);
    push(8'hDD, 1);
    send_flit(T_HT, hdr(m_dst, m_src, m_tid, 4'b0000,
                        32'hDDCCBBAA), e3, o3);
    checks++;
    if (!o3 || e3 !== 1'b1) begin
      errors++;
      $display("FAIL hdr_in_packet_err got ok=%b err=%b exp 1/1",
               o3, e3);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL errors_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_reset_mid;
    logic e, o;
    int   left;
    m_dst = 11'h111; m_src = 11'h222; m_tid = 5'h07;
    push(8'h11, 0); push(8'h22, 0);
    send_flit(T_HEAD, hdr(m_dst, m_src, m_tid, 4'b0000,
                          32'h44332211), e, o);
    @(posedge clk_noc);
    @(posedge clk_noc);
    #1;
    rst_noc = 1'b1;
    @(negedge clk_noc);
    checks++;
    if (m_axis_tvalid !== 1'b0 || network_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL in_reset got v=%b r=%b exp 0/0",
               m_axis_tvalid, network_ready_o);
    end
    @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    @(negedge clk_noc);
    checks++;
    if ({m_axis_tvalid, network_ready_o, m_axis_tlast,
         m_axis_tid, m_axis_tdest, m_axis_tuser}
        !== {1'b0, 1'b1, 1'b0, 30'h0} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset got v=%b r=%b q=%0d exp 0/1/0",
               m_axis_tvalid, network_ready_o, exp_q.size());
    end
    @(posedge clk_noc);
    #1;
    m_dst = 11'h333; m_src = 11'h444; m_tid = 5'h15;
    push(8'hA1, 0); push(8'hA2, 1);
    send_flit(T_HT, hdr(m_dst, m_src, m_tid, 4'b1100,
                        32'h0000A2A1), e, o);
    checks++;
    if (!o || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_ht_accept got ok=%b err=%b exp 1/0",
               o, e);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL reset_ht_drain got %0d left exp 0", left);
    end
  endtask

  task automatic test_back_to_back;
    logic e1, e2, o1, o2;
    int   cnt;
    int   left;
    m_dst = 11'h010; m_src = 11'h020; m_tid = 5'h03;
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
    push(8'h04, 1);
    m_dst = 11'h030; m_src = 11'h040; m_tid = 5'h04;
    push(8'h05, 0); push(8'h06, 0); push(8'h07, 0);
    push(8'h08, 1);
    send_flit(T_HT, hdr(11'h010, 11'h020, 5'h03, 4'b0000,
                        32'h04030201), e1, o1);
    cnt = 0;
    fork
      send_flit(T_HT, hdr(11'h030, 11'h040, 5'h04, 4'b0000,
                          32'h08070605), e2, o2);
      repeat (8) begin
        @(negedge clk_noc);
        if (m_axis_tvalid) cnt++;
      end
    join
    checks++;
    if (cnt != 8 || !o1 || !o2 || e1 !== 1'b0 || e2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b got %0d valid cycles ok=%b%b exp 8/11",
               cnt, o1, o2);
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d left exp 0", left);
    end
  endtask

  initial begin
    test_reset();
    test_header_and_tail();
    test_head_tail();
    test_body_hold();
    test_stall();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
